data_reg_file: RTL and testbench
================================

DATA_REG_FILE -- requirements
Module: data_reg_file

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of 16-bit entries (power of two, 2..16).
REQ-003 The block SHALL have parameter AW, default 3, giving the address width, equal to log2(DEPTH).
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port wr_en  input  1  write strobe, sampled on rising clk.
REQ-007 Port wr_addr  input  AW  write entry index.
REQ-008 Port wr_data  input  16  write value, driven by the Data_MUX Out.
REQ-009 Port rd_addr_1  input  AW  read port 1 index.
REQ-010 Port rd_addr_0  input  AW  read port 0 index.
REQ-011 Port rd_data_1  output  16  registered read port 1 data, feeds Data_MUX S_1.
REQ-012 Port rd_data_0  output  16  registered read port 0 data, feeds Data_MUX S_0.
REQ-013 Port clr  input  1  single-cycle request to zero all entries sequentially.
REQ-014 Port busy  output  1  high while the clear sequence runs.

Function
REQ-015 Write: when wr_en=1 and state=IDLE and clr=0 at a rising clk, entry[wr_addr] SHALL take wr_data.
REQ-016 Read: each rd_data_n SHALL equal entry[rd_addr_n] sampled at the previous rising clk (1-cycle latency).
REQ-017 Both read ports SHALL be independent; equal addresses SHALL return identical data.
REQ-018 The FSM SHALL have exactly two states: IDLE and CLEAR.
REQ-019 IDLE->CLEAR SHALL occur when clr=1 at a rising clk; clr_ptr loads 0 and busy rises on the same edge.
REQ-020 In CLEAR, each cycle SHALL write 0 to entry[clr_ptr] and increment clr_ptr.
REQ-021 CLEAR->IDLE SHALL occur on the edge that clears entry DEPTH-1; busy falls on that edge, so busy is high for exactly DEPTH cycles.
REQ-022 clr=1 and wr_en=1 in the same IDLE cycle: clr SHALL win and the write SHALL be dropped.
REQ-023 In CLEAR, wr_en and clr SHALL be ignored; writes are not queued.
REQ-024 Reads during CLEAR SHALL return current contents: 0 for already-cleared entries, old data otherwise.
REQ-025 clr_ptr SHALL not wrap; it stops at DEPTH-1 on exit from CLEAR and reloads 0 on the next entry to CLEAR.
REQ-026 Out-of-range addresses cannot occur, because DEPTH is 2^AW; no address checking is required.

Reset
REQ-027 On rst_n=0, asynchronously and independent of clk, all entries SHALL be set to 16'h0000.
REQ-028 On rst_n=0, rd_data_1 and rd_data_0 SHALL be set to 16'h0000.
REQ-029 On rst_n=0, busy SHALL be 0, the state SHALL be IDLE and clr_ptr SHALL be 0.
REQ-030 Reset asserted mid-CLEAR SHALL abort the sequence; after release, the block SHALL be in IDLE with all entries 0.
REQ-031 Operations SHALL resume on the first rising clk after rst_n rises.

Configuration
REQ-032 Macro DATA_REG_FILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-033 With DATA_REG_FILE_BYPASS_EN defined: if an accepted write targets rd_addr_n in the same cycle, rd_data_n SHALL take wr_data on that edge.
REQ-034 With DATA_REG_FILE_BYPASS_EN defined: in CLEAR, if clr_ptr equals rd_addr_n, rd_data_n SHALL take 0 on that edge.
REQ-035 Without the macro, rd_data_n SHALL return the pre-write entry value for same-cycle read/write, and the new value one cycle later.

Verification
REQ-036 Reset: assert rst_n=0 mid-cycle -> all rd_data = 0 and busy = 0 immediately, without waiting for a clk edge.
REQ-037 Write/read: write 16'h00FF to entry 2 and 16'h0000 to entry 5, then read rd_addr_1=5 and rd_addr_0=2 -> rd_data_1=0000, rd_data_0=00FF one cycle later.
REQ-038 Bypass: write 16'hBEEF to entry 3 while rd_addr_0=3 (old value 1234) -> rd_data_0=BEEF next cycle with the macro, 1234 without it (BEEF the cycle after).
REQ-039 Clear: fill all 8 entries with nonzero data, pulse clr -> busy high for exactly 8 cycles, then all entries read 0; wr_en pulses during busy leave no effect.
REQ-040 Priority: clr=1 and wr_en=1 to entry 4 with 16'hAAAA in the same cycle -> after clear, entry 4 reads 0.
REQ-041 Reset mid-clear: assert rst_n=0 at busy cycle 3 -> busy=0, state IDLE, entries 3..7 read 0 after release.

Source files
------------

// File: rtl/data_reg_file.sv
// Dual-read, single-write 16-bit register file with a sequential clear (one entry per cycle, busy while clearing).
// Reads are registered with 1-cycle latency; DATA_REG_FILE_BYPASS_EN forwards same-cycle writes and clears to the read ports.
module data_reg_file #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [15:0]   wr_data,
   input  logic [AW-1:0] rd_addr_1,
   input  logic [AW-1:0] rd_addr_0,
   output logic [15:0]   rd_data_1,
   output logic [15:0]   rd_data_0,
   input  logic          clr,
   output logic          busy
);
   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] clr_ptr;
   logic [15:0]   mem [DEPTH];
   logic          wr_ok;
   logic          clr_last;
   logic [15:0]   rd_nxt_1, rd_nxt_0;

   // clr beats a same-cycle write; nothing is accepted while clearing
   assign wr_ok    = (state == IDLE) && wr_en && !clr;
   assign clr_last = (clr_ptr == AW'(DEPTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clr)      state_nxt = CLEAR;
         CLEAR:   if (clr_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == CLEAR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_ptr <= '0;
      end else if (state == IDLE) begin
         if (clr) clr_ptr <= '0;
      end else if (!clr_last) begin
         clr_ptr <= clr_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (state == CLEAR) begin
         mem[clr_ptr] <= '0;
      end else if (wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_nxt_1 = mem[rd_addr_1];
      rd_nxt_0 = mem[rd_addr_0];
`ifdef DATA_REG_FILE_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr_1))             rd_nxt_1 = wr_data;
      if (wr_ok && (wr_addr == rd_addr_0))             rd_nxt_0 = wr_data;
      if ((state == CLEAR) && (clr_ptr == rd_addr_1))  rd_nxt_1 = '0;
      if ((state == CLEAR) && (clr_ptr == rd_addr_0))  rd_nxt_0 = '0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_1 <= '0;
         rd_data_0 <= '0;
      end else begin
         rd_data_1 <= rd_nxt_1;
         rd_data_0 <= rd_nxt_0;
      end
   end
endmodule

// File: tb/tb_data_reg_file.sv
// Bench for data_reg_file: vector table, directed clear/reset sequences, random traffic against an array model.
module tb_data_reg_file;
`ifdef DATA_REG_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en, clr, busy;
   logic [2:0]  wr_addr, rd_addr_1, rd_addr_0;
   logic [15:0] wr_data, rd_data_1, rd_data_0;

   int checks   = 0;
   int failures = 0;

   logic [15:0] m_mem [8];
   logic [15:0] m_rd1, m_rd0;
   bit          m_busy;
   int          m_idx;

   typedef struct {
      logic        we;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic [2:0]  a1;
      logic [2:0]  a0;
      logic        c;
      logic [15:0] e1;
      logic [15:0] e0;
      logic        eb;
   } vec_t;
   vec_t tbl[6];

   data_reg_file #(.DEPTH(8), .AW(3)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_1(rd_addr_1), .rd_addr_0(rd_addr_0), .rd_data_1(rd_data_1), .rd_data_0(rd_data_0),
      .clr(clr), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_mem[i] = '0;
      m_rd1 = '0; m_rd0 = '0; m_busy = 0; m_idx = 0;
   endtask

   // Drive one cycle of inputs, advance the model by the same edge, sample 1 time unit after the edge.
   task automatic step(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic [2:0] a1, input logic [2:0] a0, input logic c);
      logic [15:0] n1, n0;
      wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_1 = a1; rd_addr_0 = a0; clr = c;
      n1 = m_mem[a1];
      n0 = m_mem[a0];
      if (m_busy) begin
         if (BYP && m_idx == int'(a1)) n1 = '0;
         if (BYP && m_idx == int'(a0)) n0 = '0;
         m_mem[m_idx] = '0;
         if (m_idx == 7) m_busy = 0;
         else            m_idx++;
      end else if (c) begin
         m_busy = 1; m_idx = 0;
      end else if (we) begin
         if (BYP && wa == a1) n1 = wd;
         if (BYP && wa == a0) n0 = wd;
         m_mem[wa] = wd;
      end
      m_rd1 = n1; m_rd0 = n0;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_rd1"}, rd_data_1, m_rd1);
      chk({tag, "_rd0"}, rd_data_0, m_rd0);
      chk({tag, "_busy"}, {15'd0, busy}, {15'd0, m_busy});
   endtask

   // Assert reset between edges and check the outputs clear without a clock edge.
   task automatic mid_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, "_async_rd1"}, rd_data_1, 16'h0000);
      chk({tag, "_async_rd0"}, rd_data_0, 16'h0000);
      chk({tag, "_async_busy"}, {15'd0, busy}, 16'h0000);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic fill_all();
      for (int i = 0; i < 8; i++)
         step(1'b1, 3'(i), 16'h1111 * 16'(i + 1), 3'(i), 3'(7 - i), 1'b0);
   endtask

   task automatic read_all_zero(input string tag);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 3'd0, 16'h0, 3'(i), 3'(i), 1'b0);
         chk({tag, "_rd0"}, rd_data_0, 16'h0000);
         chk({tag, "_rd1"}, rd_data_1, 16'h0000);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [2:0] wa, a0, a1;

      tbl[0] = '{1'b1, 3'd2, 16'h00FF, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b0};
      tbl[1] = '{1'b1, 3'd5, 16'h0000, 3'd5, 3'd2, 1'b0, 16'h0000, 16'h00FF, 1'b0};
      tbl[2] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd2, 1'b0, 16'h0000, 16'h00FF, 1'b0};
      tbl[3] = '{1'b1, 3'd3, 16'h1234, 3'd2, 3'd0, 1'b0, 16'h00FF, 16'h0000, 1'b0};
      tbl[4] = '{1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 1'b0,
                 BYP ? 16'hBEEF : 16'h1234, BYP ? 16'hBEEF : 16'h1234, 1'b0};
      tbl[5] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd3, 1'b0, 16'h0000, 16'hBEEF, 1'b0};

      rst_n = 1'b0; wr_en = 0; clr = 0; wr_addr = 0; wr_data = 0; rd_addr_1 = 0; rd_addr_0 = 0;
      model_reset();
      #3;
      chk("reset_rd1", rd_data_1, 16'h0000);
      chk("reset_rd0", rd_data_0, 16'h0000);
      chk("reset_busy", {15'd0, busy}, 16'h0000);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].a1, tbl[i].a0, tbl[i].c);
         chk($sformatf("vec%0d_rd1", i), rd_data_1, tbl[i].e1);
         chk($sformatf("vec%0d_rd0", i), rd_data_0, tbl[i].e0);
         chk($sformatf("vec%0d_busy", i), {15'd0, busy}, {15'd0, tbl[i].eb});
      end

      mid_reset("idle_reset");
      read_all_zero("after_idle_reset");

      // Full clear with write attempts while busy
      fill_all();
      step(1'b0, 3'd0, 16'h0, 3'd1, 3'd0, 1'b1);
      chk_model("clr_start");
      n = 0;
      while (busy && n < 20) begin
         n++;
         step(1'b1, 3'($urandom_range(0, 7)), 16'hDEAD, 3'(n % 8), 3'((n + 3) % 8), 1'($urandom_range(0, 1)));
         chk_model("clr_run");
      end
      chk("busy_cycles", 16'(n), 16'd8);
      read_all_zero("after_clear");

      // clr and write in the same cycle: clr wins
      fill_all();
      step(1'b1, 3'd4, 16'hAAAA, 3'd4, 3'd4, 1'b1);
      chk_model("prio_start");
      n = 0;
      while (busy && n < 20) begin
         n++;
         step(1'b0, 3'd0, 16'h0, 3'd4, 3'd4, 1'b0);
      end
      chk("prio_busy_cycles", 16'(n), 16'd8);
      step(1'b0, 3'd0, 16'h0, 3'd4, 3'd4, 1'b0);
      chk("prio_entry4", rd_data_0, 16'h0000);

      // Reset during the third busy cycle
      fill_all();
      step(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1);
      step(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
      step(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
      chk("midclr_busy_before", {15'd0, busy}, 16'h0001);
      mid_reset("midclr_reset");
      read_all_zero("after_midclr_reset");
      step(1'b1, 3'd6, 16'h5A5A, 3'd6, 3'd6, 1'b0);
      step(1'b0, 3'd0, 16'h0, 3'd6, 3'd6, 1'b0);
      chk("post_reset_write", rd_data_1, 16'h5A5A);

      for (int i = 0; i < 400; i++) begin
         wa = 3'($urandom_range(0, 7));
         a1 = 3'($urandom_range(0, 7));
         a0 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
         if ($urandom_range(0, 5) == 0) a1 = a0;
         step(1'($urandom_range(0, 1)), wa, 16'($urandom), a1, a0, 1'($urandom_range(0, 29) == 0));
         chk_model("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
